// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM arbiter.
// Defines MEM_ADDR_WIDTH (word-address width default) when the build does not.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

  localparam int SRAM_DW      = 16;
  localparam int WAIT_CYC_DEF = 1;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester ports plus SRAM pins of sram_arbiter; slave is the arbiter view,
// master the requester/memory view.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

interface sram_arbiter_if #(
  parameter int ADDR_W = `MEM_ADDR_WIDTH
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;

  logic [ADDR_W:0]   sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_dq_i,
    output if_rdata, if_ack, d_rdata, d_ack,
    output sram_addr, sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_dq_i,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_arb_grant.sv
// Grant select between fetch and data ports. Fixed data priority by default;
// round-robin with a last-granted pointer when SRAM_ARB_RR_EN is defined.
module sram_arb_grant (
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic take,
`endif
  input  logic if_req,
  input  logic d_req,
  output logic grant_vld,
  output logic grant_d
);

`ifdef SRAM_ARB_RR_EN
  // last_d=0 means fetch was granted last, so data wins the next tie
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (take && grant_vld) begin
      last_d <= grant_d;
    end
  end

  always_comb begin
    grant_vld = if_req | d_req;
    grant_d   = d_req & (~if_req | ~last_d);
  end
`else
  always_comb begin
    grant_vld = if_req | d_req;
    grant_d   = d_req;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter mapping 32-bit word accesses onto a 16-bit async SRAM as
// LO/HI halfword accesses. Optional macro: SRAM_ARB_RR_EN (round-robin grant).
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = `MEM_ADDR_WIDTH,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  localparam logic [1:0] LAST = 2'(WAIT_CYC);

  state_t              state, state_nx;
  logic [1:0]          cnt, cnt_nx;
  logic                last;
  logic                gnt_vld, gnt_d;

  logic                a_d, a_we;
  logic [3:0]          a_be;
  logic [ADDR_W-1:0]   a_addr;
  logic [31:0]         a_wdata;
  logic [SRAM_DW-1:0]  lo_buf;

  logic                t_d, t_we;
  logic [3:0]          t_be;
  logic [ADDR_W-1:0]   t_addr;
  logic [31:0]         t_wdata;

  logic                access, hi_nx;
  logic [ADDR_W:0]     addr_nx;
  logic [15:0]         dq_o_nx;
  logic                dq_oe_nx, ce_nx, oe_nx, we_nx, ub_nx, lb_nx;

  sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .take      (state == IDLE),
`endif
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .grant_vld (gnt_vld),
    .grant_d   (gnt_d)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last     = (cnt == LAST);
    case (state)
      IDLE: if (gnt_vld) begin
        state_nx = LO;
        cnt_nx   = '0;
      end
      LO: if (last) begin
        state_nx = HI;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 2'd1;
      end
      HI: if (last) state_nx = ACK;
          else      cnt_nx   = cnt + 2'd1;
      default: state_nx = IDLE;
    endcase
  end

  // Pins are registered from the next-cycle view, so in IDLE the operands
  // come straight from the winning port rather than the latched copy.
  always_comb begin
    if (state == IDLE) begin
      t_d     = gnt_d;
      t_we    = gnt_d & bus.d_we;
      t_be    = bus.d_be;
      t_addr  = gnt_d ? bus.d_addr : bus.if_addr;
      t_wdata = bus.d_wdata;
    end else begin
      t_d     = a_d;
      t_we    = a_we;
      t_be    = a_be;
      t_addr  = a_addr;
      t_wdata = a_wdata;
    end
  end

  always_comb begin
    access   = (state_nx == LO) || (state_nx == HI);
    hi_nx    = (state_nx == HI);
    addr_nx  = bus.sram_addr;
    dq_o_nx  = '0;
    dq_oe_nx = 1'b0;
    ce_nx    = 1'b1;
    oe_nx    = 1'b1;
    we_nx    = 1'b1;
    ub_nx    = 1'b1;
    lb_nx    = 1'b1;
    if (access) begin
      ce_nx   = 1'b0;
      addr_nx = {t_addr, hi_nx};
      if (t_we) begin
        dq_oe_nx = 1'b1;
        dq_o_nx  = hi_nx ? t_wdata[31:16] : t_wdata[15:0];
        // first cycle of a waited access is address setup with we_n high
        we_nx    = (WAIT_CYC != 0) && (cnt_nx == 2'd0);
        ub_nx    = ~(hi_nx ? t_be[3] : t_be[1]);
        lb_nx    = ~(hi_nx ? t_be[2] : t_be[0]);
      end else begin
        oe_nx = 1'b0;
        ub_nx = 1'b0;
        lb_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      a_d            <= 1'b0;
      a_we           <= 1'b0;
      a_be           <= '0;
      a_addr         <= '0;
      a_wdata        <= '0;
      lo_buf         <= '0;
      bus.sram_addr  <= '0;
      bus.sram_dq_o  <= '0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_ub_n  <= 1'b1;
      bus.sram_lb_n  <= 1'b1;
      bus.if_ack     <= 1'b0;
      bus.d_ack      <= 1'b0;
      bus.if_rdata   <= '0;
      bus.d_rdata    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && gnt_vld) begin
        a_d     <= t_d;
        a_we    <= t_we;
        a_be    <= t_be;
        a_addr  <= t_addr;
        a_wdata <= t_wdata;
      end
      bus.sram_addr  <= addr_nx;
      bus.sram_dq_o  <= dq_o_nx;
      bus.sram_dq_oe <= dq_oe_nx;
      bus.sram_ce_n  <= ce_nx;
      bus.sram_oe_n  <= oe_nx;
      bus.sram_we_n  <= we_nx;
      bus.sram_ub_n  <= ub_nx;
      bus.sram_lb_n  <= lb_nx;
      bus.if_ack     <= (state_nx == ACK) && !a_d;
      bus.d_ack      <= (state_nx == ACK) && a_d;
      if (!a_we && last) begin
        if (state == LO) lo_buf <= bus.sram_dq_i;
        if (state == HI) begin
          if (a_d) bus.d_rdata  <= {bus.sram_dq_i, lo_buf};
          else     bus.if_rdata <= {bus.sram_dq_i, lo_buf};
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: halfword SRAM model, word-level
// reference memory, directed and random transactions, WAIT_CYC=1 and 0.
module tb_sram_arbiter;
  localparam int AW = 8;
  localparam int W  = 1;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) b0 ();
  sram_arbiter_if #(.ADDR_W(AW)) b1 ();

  sram_arbiter #(.ADDR_W(AW), .WAIT_CYC(W)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  sram_arbiter #(.ADDR_W(AW), .WAIT_CYC(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  logic [15:0] mem     [0:(1<<(AW+1))-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  bit          mem_ready = 1'b0;
  bit          last_d;

  function automatic logic [15:0] init_val(input int unsigned i);
    if (i == 32'hA0) return 16'h5678;
    if (i == 32'hA1) return 16'h1234;
    return 16'((i * 40503) ^ 23130);
  endfunction

  // Halfword SRAM: byte-lane writes on any clock with ce_n and we_n low
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1<<(AW+1)); i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (!b0.sram_ce_n && !b0.sram_we_n) begin
      if (!b0.sram_lb_n) mem[b0.sram_addr][7:0]  <= b0.sram_dq_o[7:0];
      if (!b0.sram_ub_n) mem[b0.sram_addr][15:8] <= b0.sram_dq_o[15:8];
    end
  end

  assign b0.sram_dq_i = (!b0.sram_ce_n && !b0.sram_oe_n) ? mem[b0.sram_addr] : 16'h0;
  assign b1.sram_dq_i = (!b1.sram_ce_n && !b1.sram_oe_n) ?
                        ({7'd0, b1.sram_addr} ^ 16'h3C5A) : 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] wd);
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
  endtask

  // Called just after a posedge with the DUT idle; returns after the ack cycle.
  task automatic txn(input bit is_d, input bit we, input logic [3:0] be,
                     input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat,
                     output bit lo_en, output int we_cnt);
    if (is_d) begin
      b0.d_req = 1'b1; b0.d_we = we; b0.d_be = be; b0.d_addr = addr; b0.d_wdata = wd;
    end else begin
      b0.if_req = 1'b1; b0.if_addr = addr;
      b0.d_we = $urandom_range(0, 1); b0.d_be = 4'($urandom);
    end
    lat = 0; lo_en = 1'b0; we_cnt = 0;
    @(negedge clk);
    while (!(is_d ? b0.d_ack : b0.if_ack) && lat < 40) begin
      if (!b0.sram_ce_n && !b0.sram_addr[0] && (!b0.sram_ub_n || !b0.sram_lb_n)) lo_en = 1'b1;
      if (!b0.sram_we_n) we_cnt++;
      lat++;
      @(negedge clk);
    end
    rd = is_d ? b0.d_rdata : b0.if_rdata;
    b0.d_req = 1'b0; b0.if_req = 1'b0;
    last_d = is_d;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, exp;
    int          lat, we_cnt, n, cyc, prev, acks, we_seen;
    bit          lo_en, is_d, we, exp_d, ack_seen;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [15:0] h_lo, h_hi;

    b0.if_req = 0; b0.if_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_be = '0;
    b0.d_addr = '0; b0.d_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_be = '0;
    b1.d_addr = '0; b1.d_wdata = '0;
    for (int a = 0; a < (1<<AW); a++) ref_mem[a] = {init_val(2*a+1), init_val(2*a)};
    last_d = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'({b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_ub_n, b0.sram_lb_n}), 32'h1F);
    check("rst_dq_oe", 32'(b0.sram_dq_oe), 32'h0);
    check("rst_addr_dq", 32'({b0.sram_addr, b0.sram_dq_o}), 32'h0);
    check("rst_acks", 32'({b0.if_ack, b0.d_ack}), 32'h0);
    check("rst_if_rdata", b0.if_rdata, 32'h0);
    check("rst_d_rdata", b0.d_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch read of a known word
    txn(1'b0, 1'b0, 4'h0, 8'h50, 32'h0, rd, lat, lo_en, we_cnt);
    check("fetch_lat", 32'(lat), 32'(2*W+3));
    check("fetch_rdata", rd, 32'h12345678);
    check("fetch_no_we", 32'(we_cnt), 32'h0);

    // Full-word write, halfword layout, read back
    txn(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, rd, lat, lo_en, we_cnt);
    ref_write(8'h10, 4'hF, 32'hDEADBEEF);
    check("wr_lat", 32'(lat), 32'(2*W+3));
    check("wr_we_cycles", 32'(we_cnt), 32'(2*W));
    check("wr_half_lo", 32'(mem[9'h20]), 32'hBEEF);
    check("wr_half_hi", 32'(mem[9'h21]), 32'hDEAD);
    txn(1'b1, 1'b0, 4'hF, 8'h10, 32'h0, rd, lat, lo_en, we_cnt);
    check("rd_back", rd, 32'hDEADBEEF);

    // Single-byte write into the HI lower lane
    txn(1'b1, 1'b1, 4'b0100, 8'h10, 32'h00AA0000, rd, lat, lo_en, we_cnt);
    ref_write(8'h10, 4'b0100, 32'h00AA0000);
    check("byte_lo_lanes_off", 32'(lo_en), 32'h0);
    check("byte_half_hi", 32'(mem[9'h21]), 32'hDEAA);
    check("byte_half_lo", 32'(mem[9'h20]), 32'hBEEF);

    // Both ports requesting continuously for four transactions
    b0.if_addr = 8'h50; b0.if_req = 1'b1;
    b0.d_we = 1'b0; b0.d_be = 4'hF; b0.d_addr = 8'h10; b0.d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(b0.if_ack || b0.d_ack) && n < 40);
      exp_d  = RR ? !last_d : 1'b1;
      last_d = exp_d;
      check("arb_grant_d", 32'(b0.d_ack), 32'(exp_d));
      check("arb_grant_if", 32'(b0.if_ack), 32'(!exp_d));
      rd  = b0.d_ack ? b0.d_rdata : b0.if_rdata;
      exp = exp_d ? ref_mem[8'h10] : ref_mem[8'h50];
      check("arb_rdata", rd, exp);
    end
    b0.if_req = 1'b0; b0.d_req = 1'b0;
    @(posedge clk); #1;

    // Random single-port traffic against the word-level reference
    for (int i = 0; i < 24; i++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      be   = 4'($urandom);
      addr = 8'($urandom);
      wd   = $urandom;
      txn(is_d, we, be, addr, wd, rd, lat, lo_en, we_cnt);
      check("rnd_lat", 32'(lat), 32'(2*W+3));
      if (we) begin
        ref_write(addr, be, wd);
        check("rnd_we_cycles", 32'(we_cnt), 32'(2*W));
      end else begin
        check("rnd_rdata", rd, ref_mem[addr]);
        check("rnd_no_we", 32'(we_cnt), 32'h0);
      end
    end

    // Reset pulse in HI of a write; the write is then re-issued
    wd = 32'hCAFE0123;
    b0.d_req = 1'b1; b0.d_we = 1'b1; b0.d_be = 4'hF; b0.d_addr = 8'h30; b0.d_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!(!b0.sram_ce_n && b0.sram_addr[0]) && n < 20);
    check("rst_mid_reach_hi", 32'(n < 20), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'({b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_ub_n, b0.sram_lb_n}), 32'h1F);
    check("rst_mid_dq_oe", 32'(b0.sram_dq_oe), 32'h0);
    b0.d_req = 1'b0;
    last_d   = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (b0.d_ack || b0.if_ack) ack_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (b0.d_ack || b0.if_ack) ack_seen = 1'b1; end
    check("rst_mid_no_ack", 32'(ack_seen), 32'h0);
    @(posedge clk); #1;
    txn(1'b1, 1'b1, 4'hF, 8'h30, wd, rd, lat, lo_en, we_cnt);
    ref_write(8'h30, 4'hF, wd);
    check("reissue_lat", 32'(lat), 32'(2*W+3));
    txn(1'b0, 1'b0, 4'h0, 8'h30, 32'h0, rd, lat, lo_en, we_cnt);
    check("reissue_rdata", rd, ref_mem[8'h30]);

    // Zero-wait instance: back-to-back fetches from a held request
    h_lo = {7'd0, 8'h33, 1'b0} ^ 16'h3C5A;
    h_hi = {7'd0, 8'h33, 1'b1} ^ 16'h3C5A;
    b1.if_addr = 8'h33; b1.if_req = 1'b1;
    cyc = 0; prev = 0; acks = 0; we_seen = 0;
    while (acks < 4 && cyc < 60) begin
      @(negedge clk);
      if (!b1.sram_we_n) we_seen++;
      if (b1.if_ack) begin
        if (acks == 0) check("w0_first_lat", 32'(cyc), 32'd3);
        else           check("w0_ack_gap", 32'(cyc - prev), 32'd4);
        check("w0_rdata", b1.if_rdata, {h_hi, h_lo});
        prev = cyc;
        acks++;
      end
      cyc++;
    end
    b1.if_req = 1'b0;
    check("w0_acks", 32'(acks), 32'd4);
    check("w0_no_we", 32'(we_seen), 32'h0);
    @(negedge clk);
    check("w0_ack_one_cycle", 32'(b1.if_ack), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter ADDR_W, default `MEM_ADDR_WIDTH, word-address width of both requester ports.
REQ-003 SHALL have parameter WAIT_CYC, default 1, extra cycles per SRAM halfword access (range 0-3).
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst_n  in  1  async active-low reset.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W, if_rdata out 32, if_ack out 1; this is the instruction-fetch read port.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_be in 4, d_addr in ADDR_W, d_wdata in 32, d_rdata out 32, d_ack out 1; this is the data port.
REQ-008 SHALL have ports sram_addr out ADDR_W+1 (halfword address), sram_dq_o out 16, sram_dq_oe out 1, sram_dq_i in 16, and sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, each out 1 and active-low.

Function
REQ-009 SHALL use FSM states IDLE, LO, HI, ACK; each 32-bit word is two 16-bit SRAM accesses: LO at {addr,0} (bits 15:0), then HI at {addr,1} (bits 31:16).
REQ-010 SHALL, in IDLE, sample requests and grant one port, latching its address, we, be and wdata; LO follows in the next cycle.
REQ-011 SHALL hold LO and HI for WAIT_CYC+1 cycles each; ACK lasts one cycle, then the FSM returns to IDLE.
REQ-012 SHALL assert the granted port's ack for exactly one cycle in ACK; with a request first seen at cycle 0 in IDLE, ack occurs at cycle 2*WAIT_CYC+3.
REQ-013 SHALL present read data on if_rdata/d_rdata together with ack, and hold it until that port's next ack.
REQ-014 SHALL capture sram_dq_i in the last cycle of each read access.
REQ-015 SHALL require requesters to hold req and operands stable until ack; a req still high in the cycle after ack is treated as a new request.
REQ-016 SHALL, on a write, drive sram_dq_oe=1 and the halfword on sram_dq_o for the whole access.
REQ-017 SHALL drive sram_we_n low for the whole access when WAIT_CYC=0, and for all but the first cycle of the access otherwise (address setup).
REQ-018 SHALL map byte enables as follows: LO uses lb_n=!d_be[0], ub_n=!d_be[1]; HI uses lb_n=!d_be[2], ub_n=!d_be[3]. A halfword whose enables are both zero still gets its access cycle, with no byte written.
REQ-019 SHALL keep ub_n=lb_n=0 on reads and assert oe_n low only during read accesses.
REQ-020 SHALL keep sram_ce_n low in LO and HI, and high in IDLE and ACK.
REQ-021 SHALL register all SRAM outputs (no combinational paths from req to pins).
REQ-022 SHALL, when both requests are high in IDLE, grant the data port unless SRAM_ARB_RR_EN is defined.
REQ-023 SHALL ignore d_we/d_be for the fetch port; the fetch port is read-only.

Reset
REQ-024 SHALL, while rst_n=0, force FSM=IDLE, ce_n/oe_n/we_n/ub_n/lb_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, acks=0, if_rdata=d_rdata=0, and RR pointer="fetch last".
REQ-025 SHALL, when reset is asserted mid-transaction, abort it immediately with no ack; the requester re-issues the request after reset.

Configuration
REQ-026 SHALL, with SRAM_ARB_RR_EN defined, resolve simultaneous requests round-robin: the port not granted last wins, and the pointer updates at each grant.
REQ-027 SHALL, without SRAM_ARB_RR_EN, use fixed data-port priority with no pointer register; fetch may starve under continuous data requests.

Structure
REQ-028 SHALL put the FSM state typedef, SRAM_DW=16, and WAIT_CYC default in shared package sram_arb_pkg.
REQ-029 SHALL implement arbitration (grant select plus RR pointer) in sub-module sram_arb_grant.

Verification
REQ-030 SHALL cover a fetch read with WAIT_CYC=1 and memory {0x00A0}=0x5678, {0x00A1}=0x1234: if_addr=0x50 gives if_ack at cycle 5 with if_rdata=0x12345678.
REQ-031 SHALL cover a data write of 0xDEADBEEF at d_be=4'b1111, d_addr=0x10: SRAM halfwords 0x20=0xBEEF and 0x21=0xDEAD, then a read returns 0xDEADBEEF.
REQ-032 SHALL cover a byte write with d_be=4'b0100 and wdata=0x00AA0000: only the lb half of halfword 0x21 changes to 0xAA; ub_n=1 and lb_n=1 throughout LO.
REQ-033 SHALL cover simultaneous if_req and d_req held for 4 transactions: with no macro all 4 grants go to data; with SRAM_ARB_RR_EN the grants go data, fetch, data, fetch.
REQ-034 SHALL cover rst_n pulsed low during HI of a write: no ack is issued, all SRAM controls are high within the same cycle, and dq_oe=0.
REQ-035 SHALL cover WAIT_CYC=0 with back-to-back fetches: one ack every 4 cycles, and we_n never asserted.
